// File: rtl/hex_msg_scheduler.sv
// hex_msg_scheduler: round-robin time-sharing of the 4-character seven-segment
// message path. Shows the background text when idle. A granted message is held
// for HOLD_CYCLES, then the display goes blank for GAP_CYCLES.
module hex_msg_scheduler #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 5000000
) (
    input  logic               CLOCK_50,
    input  logic               KEY0,
    input  logic [31:0]        bg_msg,
    input  logic [NREQ-1:0]    req,
    input  logic [32*NREQ-1:0] msg,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [31:0]        disp_msg
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = $clog2(NREQ);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [31:0]   BLANK     = 32'h20202020;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t          state, n_state;
    logic [CW-1:0]   cnt, n_cnt;
    logic [PW-1:0]   rr_ptr, n_ptr;
    logic [NREQ-1:0] n_grant, n_done, win_oh;
    logic [31:0]     n_disp;
    logic [PW-1:0]   win;
    logic            found;
    int              idx;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        idx    = 0;
        win_oh = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        win_oh[win] = 1'b1;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        n_state = state;
        n_cnt   = cnt;
        n_ptr   = rr_ptr;
        n_grant = grant;
        n_done  = '0;
        n_disp  = disp_msg;
        case (state)
            IDLE: begin
                n_disp = bg_msg;
                if (found) begin
                    n_state = SHOW;
                    n_grant = win_oh;
                    n_ptr   = win;
                    n_disp  = msg[32*int'(win) +: 32];
                    n_cnt   = '0;
                end
            end
            SHOW: begin
                n_cnt = cnt + CW'(1);
                // A dropped request aborts the message and suppresses done.
                if (!req[rr_ptr] || cnt == HOLD_LAST) begin
                    n_state = GAP;
                    n_grant = '0;
                    n_disp  = BLANK;
                    n_cnt   = '0;
                    if (req[rr_ptr])
                        n_done = grant;
                end
            end
            GAP: begin
                n_cnt = cnt + CW'(1);
                if (cnt == GAP_LAST) begin
                    n_state = IDLE;
                    n_cnt   = '0;
                end
            end
            default: begin
                n_state = IDLE;
                n_grant = '0;
                n_disp  = BLANK;
                n_cnt   = '0;
            end
        endcase
    end

    // State, counter, pointer and output registers.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_ptr   <= PW'(NREQ - 1);
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
            disp_msg <= BLANK;
        end else begin
            state    <= n_state;
            cnt      <= n_cnt;
            rr_ptr   <= n_ptr;
            grant    <= n_grant;
            done     <= n_done;
            busy     <= (n_state != IDLE);
            disp_msg <= n_disp;
        end
    end

endmodule

// File: tb/tb_hex_msg_scheduler.sv
// Scoreboard bench for hex_msg_scheduler (NREQ=4, HOLD=8, GAP=2).
module tb_hex_msg_scheduler;

    localparam int NREQ = 4;
    localparam logic [31:0] BLANK = 32'h20202020;

    logic              CLOCK_50 = 1'b0;
    logic              KEY0     = 1'b1;
    logic [31:0]       bg_msg   = '0;
    logic [NREQ-1:0]   req      = '0;
    logic [32*NREQ-1:0] msg     = '0;
    logic [NREQ-1:0]   grant, done;
    logic              busy;
    logic [31:0]       disp_msg;

    hex_msg_scheduler #(.NREQ(NREQ), .HOLD_CYCLES(8), .GAP_CYCLES(2)) dut (
        .CLOCK_50(CLOCK_50), .KEY0(KEY0), .bg_msg(bg_msg), .req(req), .msg(msg),
        .grant(grant), .done(done), .busy(busy), .disp_msg(disp_msg)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [31:0]     d;
        int              len;
        bit              dn;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0, bad = 0;
    int   cyc = 0, last_rise = 0, run = 0;
    bit   active = 0, spacing_on = 0, have_rise = 0;
    logic [NREQ-1:0] prev_g = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic [31:0] d, input int len, input bit dn);
        exp_t e;
        e.g = g; e.d = d; e.len = len; e.dn = dn;
        sb.push_back(e);
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (grant != 0) return;
        end
        chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (done != 0) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!busy) begin
                tick(1);
                chk("idle_bg", disp_msg, bg_msg);
                return;
            end
        end
        chk("idle_timeout", 32'd0, 32'd1);
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Output monitor: pops an expectation on each grant rise, checks hold and completion.
    always @(negedge CLOCK_50) begin
        if (!KEY0) begin
            active = 0;
            prev_g = '0;
        end else begin
            if (grant != 0 && prev_g == 0) begin
                if (sb.size() == 0) begin
                    chk("unexp_grant", 32'(grant), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("grant", 32'(grant), 32'(cur.g));
                    chk("disp_show", disp_msg, cur.d);
                    run = 1;
                    active = 1;
                    if (spacing_on) begin
                        if (have_rise) chk("spacing", 32'(cyc - last_rise), 32'd11);
                        have_rise = 1;
                        last_rise = cyc;
                    end
                end
            end else if (grant != 0 && active) begin
                run++;
                chk("disp_hold", disp_msg, cur.d);
                chk("grant_hold", 32'(grant), 32'(cur.g));
            end else if (grant == 0 && prev_g != 0 && active) begin
                chk("len", 32'(run), 32'(cur.len));
                chk("done", 32'(done), cur.dn ? 32'(cur.g) : 32'd0);
                chk("disp_gap", disp_msg, BLANK);
                chk("busy_gap", 32'(busy), 32'd1);
                active = 0;
            end
            prev_g = grant;
        end
    end

    initial begin
        // Reset state
        #1 KEY0 = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_disp", disp_msg, BLANK);
        tick(2);
        KEY0 = 1'b1;
        bg_msg = 32'h416C6D6F;
        tick(1);
        chk("bg_almo", disp_msg, 32'h416C6D6F);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        bg_msg = 32'h535F3031;
        tick(1);
        chk("bg_s01", disp_msg, 32'h535F3031);

        // Single request, normal completion
        msg[64 +: 32] = 32'h45727232;
        push(4'b0100, 32'h45727232, 8, 1);
        req = 4'b0100;
        wait_done();
        chk("done_2", 32'(done), 32'b0100);
        chk("done_blank", disp_msg, BLANK);
        req = '0;
        tick(1);
        chk("gap2_blank", disp_msg, BLANK);
        chk("gap2_done", 32'(done), 32'd0);
        wait_idle();

        // Continuous requests from reset: order 0,1,3,0,1,3, spacing 11
        KEY0 = 1'b0;
        tick(1);
        KEY0 = 1'b1;
        msg = {32'h4D337878, 32'h4D327878, 32'h4D317878, 32'h4D307878};
        for (int r = 0; r < 2; r++) begin
            push(4'b0001, 32'h4D307878, 8, 1);
            push(4'b0010, 32'h4D317878, 8, 1);
            push(4'b1000, 32'h4D337878, 8, 1);
        end
        spacing_on = 1;
        have_rise = 0;
        req = 4'b1011;
        for (int i = 0; i < 6; i++) wait_done();
        req = '0;
        wait_idle();
        spacing_on = 0;

        // Abort: requester 1 drops in the 4th SHOW cycle
        push(4'b0010, 32'h4D317878, 4, 0);
        req = 4'b0010;
        wait_grant();
        tick(3);
        req = '0;
        tick(1);
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_done1", 32'(done), 32'd0);
        chk("abort_blank", disp_msg, BLANK);
        tick(1);
        chk("abort_done2", 32'(done), 32'd0);
        chk("abort_blank2", disp_msg, BLANK);
        push(4'b0001, 32'h4D307878, 8, 1);
        push(4'b0010, 32'h4D317878, 8, 1);
        req = 4'b0011;
        wait_done();
        wait_done();
        req = '0;
        wait_idle();

        // msg change during SHOW is ignored
        push(4'b0001, 32'h4D307878, 8, 1);
        req = 4'b0001;
        wait_grant();
        tick(2);
        msg[31:0] = 32'h43484E47;
        wait_done();
        req = '0;
        wait_idle();

        // Reset mid-SHOW, then arbitration restarts at requester 0
        push(4'b0010, 32'h4D317878, 8, 1);
        req = 4'b0011;
        wait_grant();
        tick(4);
        #2 KEY0 = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_disp", disp_msg, BLANK);
        tick(2);
        push(4'b0001, 32'h43484E47, 8, 1);
        push(4'b0010, 32'h4D317878, 8, 1);
        KEY0 = 1'b1;
        wait_done();
        wait_done();
        req = '0;
        wait_idle();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
